// File: rtl/tuner_seq_ctrl_if.sv
// Handshake and peak-data bus between the tuner sequencer
// and the tuner_phy search/lock consumer sides.
interface tuner_seq_ctrl_if #(
  parameter int DAC_WIDTH  = 8,
  parameter int ADC_WIDTH  = 8,
  parameter int NUM_TARGET = 8,
  localparam int IDXW = $clog2(NUM_TARGET)
);

  logic search_trig_val;
  logic search_trig_rdy;
  logic search_peaks_val;
  logic search_peaks_rdy;

  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] ring_tune_peaks;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] pwr_peaks;
  logic [IDXW:0]                        peaks_cnt;

  logic [DAC_WIDTH-1:0] cfg_ring_tune_peak;
  logic [ADC_WIDTH-1:0] cfg_pwr_peak;

  logic lock_trig_val;
  logic lock_trig_rdy;
  logic lock_intr_val;
  logic lock_intr_rdy;
  logic lock_resume_val;
  logic lock_resume_rdy;

  modport master (
    output search_trig_val,
    input  search_trig_rdy,
    input  search_peaks_val,
    output search_peaks_rdy,
    input  ring_tune_peaks,
    input  pwr_peaks,
    input  peaks_cnt,
    output cfg_ring_tune_peak,
    output cfg_pwr_peak,
    output lock_trig_val,
    input  lock_trig_rdy,
    input  lock_intr_val,
    output lock_intr_rdy,
    output lock_resume_val,
    input  lock_resume_rdy
  );

  modport slave (
    input  search_trig_val,
    output search_trig_rdy,
    output search_peaks_val,
    input  search_peaks_rdy,
    output ring_tune_peaks,
    output pwr_peaks,
    output peaks_cnt,
    input  cfg_ring_tune_peak,
    input  cfg_pwr_peak,
    input  lock_trig_val,
    output lock_trig_rdy,
    output lock_intr_val,
    input  lock_intr_rdy,
    input  lock_resume_val,
    output lock_resume_rdy
  );

endinterface

// File: rtl/tuner_seq_ctrl.sv
// Tuner ring sequencer: search, pick one peak by index,
// lock on it and resume after lock loss a bounded number of times.
module tuner_seq_ctrl #(
  parameter int DAC_WIDTH  = 8,
  parameter int ADC_WIDTH  = 8,
  parameter int NUM_TARGET = 8,
  parameter int MAX_RETRY  = 3,
  localparam int IDXW = $clog2(NUM_TARGET),
  localparam int RW   = $clog2(MAX_RETRY + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic [IDXW-1:0] i_target_idx,
  tuner_seq_ctrl_if.master bus,
  output logic            o_locked,
  output logic [1:0]      o_err,
  output logic [RW-1:0]   o_retry_cnt,
  output logic [3:0]      o_state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S_TRIG = 4'd1,
    S_WAIT = 4'd2,
    SELECT = 4'd3,
    L_TRIG = 4'd4,
    LOCKED = 4'd5,
    RESUME = 4'd6,
    ERROR  = 4'd7
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_PEAK  = 2'd1;
  localparam logic [1:0] ERR_RETRY = 2'd2;

  state_t state_q;
  state_t state_d;

  logic [IDXW-1:0]      idx_q;
  logic [DAC_WIDTH-1:0] tune_q;
  logic [ADC_WIDTH-1:0] pwr_q;
  logic [IDXW:0]        cnt_q;
  logic [DAC_WIDTH-1:0] cfg_tune_q;
  logic [ADC_WIDTH-1:0] cfg_pwr_q;
  logic [1:0]           err_q;
  logic [RW-1:0]        retry_q;

  logic start_acc;
  logic peaks_xfer;
  logic intr_xfer;
  logic sel_bad;
  logic retry_ok;

  assign start_acc  = i_start && !i_stop
                   && (state_q == IDLE || state_q == ERROR);
  assign peaks_xfer = bus.search_peaks_val && bus.search_peaks_rdy;
  assign intr_xfer  = bus.lock_intr_val && bus.lock_intr_rdy;
  assign sel_bad    = (cnt_q == '0) || ({1'b0, idx_q} >= cnt_q);
  assign retry_ok   = retry_q < RW'(MAX_RETRY);

  // Moore val outputs and stop-gated rdy outputs from the state register
  always_comb begin
    bus.search_trig_val  = 1'b0;
    bus.search_peaks_rdy = 1'b0;
    bus.lock_trig_val    = 1'b0;
    bus.lock_intr_rdy    = 1'b0;
    bus.lock_resume_val  = 1'b0;
    o_locked             = 1'b0;
    unique case (1'b1)
      state_q == S_TRIG: bus.search_trig_val = 1'b1;
      state_q == S_WAIT: bus.search_peaks_rdy = !i_stop;
      state_q == L_TRIG: bus.lock_trig_val = 1'b1;
      state_q == LOCKED: begin
        bus.lock_intr_rdy = !i_stop;
        o_locked          = 1'b1;
      end
      state_q == RESUME: bus.lock_resume_val = 1'b1;
      default: ;
    endcase
  end

  // next-state decode; stop overrides every other event
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ERROR:
        if (start_acc) state_d = S_TRIG;
      S_TRIG:
        if (bus.search_trig_rdy) state_d = S_WAIT;
      S_WAIT:
        if (peaks_xfer) state_d = SELECT;
      SELECT:
        state_d = sel_bad ? ERROR : L_TRIG;
      L_TRIG:
        if (bus.lock_trig_rdy) state_d = LOCKED;
      LOCKED:
        if (intr_xfer) state_d = retry_ok ? RESUME : ERROR;
      RESUME:
        if (bus.lock_resume_rdy) state_d = LOCKED;
      default:
        state_d = IDLE;
    endcase
    if (i_stop) state_d = IDLE;
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // captured index/peak data, lock config, error and retry bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q      <= '0;
      tune_q     <= '0;
      pwr_q      <= '0;
      cnt_q      <= '0;
      cfg_tune_q <= '0;
      cfg_pwr_q  <= '0;
      err_q      <= ERR_NONE;
      retry_q    <= '0;
    end else begin
      if (start_acc) begin
        idx_q   <= i_target_idx;
        err_q   <= ERR_NONE;
        retry_q <= '0;
      end
      if (peaks_xfer) begin
        tune_q <= bus.ring_tune_peaks[idx_q];
        pwr_q  <= bus.pwr_peaks[idx_q];
        cnt_q  <= bus.peaks_cnt;
      end
      if (state_q == SELECT && !i_stop) begin
        if (sel_bad) begin
          err_q <= ERR_PEAK;
        end else begin
          cfg_tune_q <= tune_q;
          cfg_pwr_q  <= pwr_q;
        end
      end
      if (intr_xfer) begin
        if (retry_ok) retry_q <= retry_q + RW'(1);
        else          err_q   <= ERR_RETRY;
      end
      if (i_stop) err_q <= ERR_NONE;
    end
  end

  assign bus.cfg_ring_tune_peak = cfg_tune_q;
  assign bus.cfg_pwr_peak       = cfg_pwr_q;
  assign o_err                  = err_q;
  assign o_retry_cnt            = retry_q;
  assign o_state                = state_q;

endmodule

// File: tb/tb_tuner_seq_ctrl.sv
// Directed bench for tuner_seq_ctrl: lock flow, backpressure,
// bad peak index, retry exhaustion, stop priority and async reset.
module tb_tuner_seq_ctrl;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_STRIG  = 4'd1;
  localparam logic [3:0] ST_SWAIT  = 4'd2;
  localparam logic [3:0] ST_LTRIG  = 4'd4;
  localparam logic [3:0] ST_LOCKED = 4'd5;
  localparam logic [3:0] ST_RESUME = 4'd6;
  localparam logic [3:0] ST_ERROR  = 4'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] idx = '0;
  logic       locked;
  logic [1:0] err;
  logic [1:0] retry;
  logic [3:0] state;

  int total = 0;
  int bad = 0;
  int n_strig = 0;
  int n_ltrig = 0;
  int n_res = 0;
  int n_intr = 0;
  int snap;
  int hold;

  always #5 clk = ~clk;

  tuner_seq_ctrl_if #(
    .DAC_WIDTH(8), .ADC_WIDTH(8), .NUM_TARGET(8)
  ) bus ();

  tuner_seq_ctrl #(
    .DAC_WIDTH(8), .ADC_WIDTH(8),
    .NUM_TARGET(8), .MAX_RETRY(3)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .i_target_idx (idx),
    .bus          (bus),
    .o_locked     (locked),
    .o_err        (err),
    .o_retry_cnt  (retry),
    .o_state      (state)
  );

  always @(posedge clk) begin
    if (bus.search_trig_val && bus.search_trig_rdy) n_strig <= n_strig + 1;
    if (bus.lock_trig_val && bus.lock_trig_rdy)     n_ltrig <= n_ltrig + 1;
    if (bus.lock_resume_val && bus.lock_resume_rdy) n_res   <= n_res + 1;
    if (bus.lock_intr_val && bus.lock_intr_rdy)     n_intr  <= n_intr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go(input logic [2:0] i);
    start = 1'b1;
    idx   = i;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    bus.search_trig_rdy  = 1'b1;
    bus.search_peaks_val = 1'b1;
    bus.lock_trig_rdy    = 1'b1;
    bus.lock_intr_val    = 1'b0;
    bus.lock_resume_rdy  = 1'b1;
    bus.peaks_cnt        = 4'd3;
    for (int i = 0; i < 8; i++) begin
      bus.ring_tune_peaks[i] = 8'(8'hE0 + i);
      bus.pwr_peaks[i]       = 8'(8'h10 + i);
    end
    bus.ring_tune_peaks[0] = 8'd10;
    bus.ring_tune_peaks[1] = 8'd40;
    bus.ring_tune_peaks[2] = 8'd90;
    bus.pwr_peaks[0] = 8'd200;
    bus.pwr_peaks[1] = 8'd180;
    bus.pwr_peaks[2] = 8'd150;

    #12;
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_vals", 32'({bus.search_trig_val, bus.search_peaks_rdy,
        bus.lock_trig_val, bus.lock_intr_rdy, bus.lock_resume_val}), 0);
    chk("rst_cfg", 32'({bus.cfg_ring_tune_peak, bus.cfg_pwr_peak}), 0);
    chk("rst_misc", 32'({locked, err, retry}), 0);
    rst_n = 1'b1;
    tick();

    // basic lock on index 1
    go(3'd1);
    chk("t1_trig_lat", 32'(bus.search_trig_val), 1);
    chk("t1_state_trig", 32'(state), 32'(ST_STRIG));
    ticks(3);
    chk("t1_ltrig", 32'(bus.lock_trig_val), 1);
    tick();
    chk("t1_locked", 32'(locked), 1);
    chk("t1_tune", 32'(bus.cfg_ring_tune_peak), 40);
    chk("t1_pwr", 32'(bus.cfg_pwr_peak), 180);
    chk("t1_n_strig", 32'(n_strig), 1);
    chk("t1_n_ltrig", 32'(n_ltrig), 1);

    // backpressure on search and lock triggers
    halt();
    chk("t2_stop_idle", 32'(state), 32'(ST_IDLE));
    chk("t2_stop_val", 32'(bus.search_trig_val | bus.lock_intr_rdy), 0);
    chk("t2_cfg_hold", 32'(bus.cfg_ring_tune_peak), 40);
    bus.search_trig_rdy = 1'b0;
    bus.lock_trig_rdy   = 1'b0;
    snap = n_strig;
    go(3'd1);
    hold = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.search_trig_val) hold++;
      tick();
    end
    chk("t2_strig_hold", 32'(hold), 7);
    chk("t2_strig_none", 32'(n_strig - snap), 0);
    bus.search_trig_rdy = 1'b1;
    tick();
    chk("t2_strig_one", 32'(n_strig - snap), 1);
    chk("t2_swait", 32'(state), 32'(ST_SWAIT));
    snap = n_ltrig;
    ticks(2);
    hold = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.lock_trig_val) hold++;
      tick();
    end
    chk("t2_ltrig_hold", 32'(hold), 7);
    bus.lock_trig_rdy = 1'b1;
    tick();
    chk("t2_ltrig_one", 32'(n_ltrig - snap), 1);
    chk("t2_locked", 32'(state), 32'(ST_LOCKED));

    // invalid peak index and empty peak list
    halt();
    snap = n_ltrig;
    go(3'd3);
    ticks(3);
    chk("t3_err_state", 32'(state), 32'(ST_ERROR));
    chk("t3_err_code", 32'(err), 1);
    ticks(2);
    chk("t3_no_ltrig", 32'(n_ltrig - snap), 0);
    chk("t3_cfg_hold", 32'(bus.cfg_ring_tune_peak), 40);
    bus.peaks_cnt = 4'd0;
    go(3'd0);
    chk("t3_err_clr", 32'(err), 0);
    ticks(3);
    chk("t3_cnt0_err", 32'({state, err}), 32'({ST_ERROR, 2'd1}));
    chk("t3_cnt0_noltrig", 32'(n_ltrig - snap), 0);
    bus.peaks_cnt = 4'd3;
    go(3'd0);
    ticks(4);
    chk("t3_recover", 32'(locked), 1);
    chk("t3_cfg0", 32'({bus.cfg_ring_tune_peak, bus.cfg_pwr_peak}),
        32'({8'd10, 8'd200}));

    // retry budget
    snap = n_res;
    for (int k = 1; k <= 3; k++) begin
      bus.lock_intr_val = 1'b1;
      tick();
      bus.lock_intr_val = 1'b0;
      chk("t4_resume_st", 32'(state), 32'(ST_RESUME));
      chk("t4_retry", 32'(retry), 32'(k));
      tick();
      chk("t4_relock", 32'(state), 32'(ST_LOCKED));
    end
    bus.lock_intr_val = 1'b1;
    tick();
    bus.lock_intr_val = 1'b0;
    chk("t4_exhaust", 32'({state, err}), 32'({ST_ERROR, 2'd2}));
    chk("t4_no_resume", 32'(bus.lock_resume_val), 0);
    chk("t4_n_res", 32'(n_res - snap), 3);

    // stop beats interrupt and start
    go(3'd2);
    ticks(4);
    chk("t5_cfg2", 32'(bus.cfg_ring_tune_peak), 90);
    snap = n_intr;
    bus.lock_intr_val = 1'b1;
    stop = 1'b1;
    #1;
    chk("t5_intr_rdy", 32'(bus.lock_intr_rdy), 0);
    tick();
    bus.lock_intr_val = 1'b0;
    stop = 1'b0;
    chk("t5_idle", 32'(state), 32'(ST_IDLE));
    chk("t5_no_ack", 32'(n_intr - snap), 0);
    chk("t5_err_clr", 32'({err, retry}), 0);
    start = 1'b1;
    stop  = 1'b1;
    idx   = 3'd1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("t5_start_stop", 32'({state, bus.search_trig_val}), 0);

    // async reset while resuming
    go(3'd1);
    ticks(4);
    bus.lock_resume_rdy = 1'b0;
    bus.lock_intr_val = 1'b1;
    tick();
    bus.lock_intr_val = 1'b0;
    chk("t6_resume", 32'(bus.lock_resume_val), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_val", 32'(bus.lock_resume_val), 0);
    chk("t6_rst_state", 32'(state), 32'(ST_IDLE));
    chk("t6_rst_cfg", 32'({bus.cfg_ring_tune_peak, bus.cfg_pwr_peak}), 0);
    chk("t6_rst_misc", 32'({locked, err, retry}), 0);
    #2;
    rst_n = 1'b1;
    bus.lock_resume_rdy = 1'b1;
    tick();
    go(3'd1);
    ticks(4);
    chk("t6_restart", 32'({locked, bus.cfg_ring_tune_peak}),
        32'({1'b1, 8'd40}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
